// File: rtl/cnr_sar_pkg.sv
// Shared types and width helpers for the SAR controller.
package cnr_sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_COMPARE,
    S_WAIT,
    S_DONE
  } sar_state_e;

  localparam int NBITS_DEF         = 8;
  localparam int SAMPLE_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF       = 8;

  // One counter serves both the sample hold and the per-bit timeout, so it is
  // sized for whichever of the two needs the larger terminal value.
  function automatic int cnt_w(input int sample_cycles, input int timeout);
    int m;
    m = (sample_cycles > timeout) ? sample_cycles : timeout;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

  function automatic int idx_w(input int nbits);
    return ($clog2(nbits) < 1) ? 1 : $clog2(nbits);
  endfunction

  localparam int CNT_W_DEF = cnt_w(SAMPLE_CYCLES_DEF, TIMEOUT_DEF);
  localparam int IDX_W_DEF = idx_w(NBITS_DEF);

endpackage

// File: rtl/cnr_sar_cnt.sv
// Loadable up/down counter with a terminal-count compare.
module cnr_sar_cnt #(
  parameter int W = 3
) (
  input  logic         CK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority over counting; hold when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = load_val;
    else if (en) cnt_d = up ? cnt_q + W'(1) : cnt_q - W'(1);
  end

  // Counter register.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/cnr_sar_ctrl.sv
// Successive-approximation controller: sample, then resolve one bit per
// COMPARE/WAIT pair from MSB to LSB, with a per-bit comparator timeout.
module cnr_sar_ctrl
  import cnr_sar_pkg::*;
#(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int TIMEOUT       = 8
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             CMP_VALID,
  input  logic             CMP_OUT,
  output logic             SAMPLE,
  output logic             CMP_EN,
  output logic [NBITS-1:0] DAC,
  output logic [NBITS-1:0] DOUT,
  output logic             DONE,
  output logic             BUSY,
  output logic             TOUT
);

  localparam int CW = cnt_w(SAMPLE_CYCLES, TIMEOUT);
  localparam int IW = idx_w(NBITS);
  localparam logic [CW-1:0] SMP_LOAD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  sar_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             tout_q, tout_d;

  logic             cnt_load, cnt_en, cnt_up, cnt_tc;
  logic [CW-1:0]    cnt_val, cnt_tc_val;

  // SAMPLE counts down to 0; WAIT counts up to TIMEOUT-1.
  assign cnt_tc_val = (state_q == S_SAMPLE) ? '0 : TO_LAST;

  cnr_sar_cnt #(.W(CW)) u_cnt (
    .CK       (CK),
    .RST_N    (RST_N),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .up       (cnt_up),
    .tc_val   (cnt_tc_val),
    .tc       (cnt_tc)
  );

  // Next-state, bit resolution and counter control.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dac_d    = dac_q;
    dout_d   = dout_q;
    tout_d   = tout_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    cnt_up   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_SAMPLE;
          dac_d    = '0;
          tout_d   = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = SMP_LOAD;
        end
      end
      S_SAMPLE: begin
        if (cnt_tc) begin
          state_d          = S_COMPARE;
          idx_d            = IW'(NBITS - 1);
          dac_d            = '0;
          dac_d[NBITS-1]   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_COMPARE: begin
        state_d  = S_WAIT;
        cnt_load = 1'b1;
        cnt_val  = '0;
      end
      S_WAIT: begin
        // A real decision beats a timeout landing in the same cycle.
        if (CMP_VALID) begin
          dac_d[idx_q] = CMP_OUT;
        end else if (cnt_tc) begin
          dac_d[idx_q] = 1'b0;
          tout_d       = 1'b1;
        end else begin
          cnt_en = 1'b1;
          cnt_up = 1'b1;
        end
        if (CMP_VALID || cnt_tc) begin
          if (idx_q == '0) begin
            state_d = S_DONE;
            dout_d  = dac_d;
          end else begin
            idx_d                 = idx_q - IW'(1);
            dac_d[idx_q - IW'(1)] = 1'b1;
            state_d               = S_COMPARE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dac_q   <= '0;
      dout_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dac_q   <= dac_d;
      dout_q  <= dout_d;
      tout_q  <= tout_d;
    end
  end

  assign SAMPLE = (state_q == S_SAMPLE);
  assign CMP_EN = (state_q == S_COMPARE);
  assign DONE   = (state_q == S_DONE);
  assign BUSY   = (state_q != S_IDLE);
  assign DAC    = dac_q;
  assign DOUT   = dout_q;
  assign TOUT   = tout_q;

endmodule
